uart_tx_frame: RTL and testbench
================================

Name: uart_tx_frame

Overview:
UART transmitter that drives the board's UART_TXD pin. It serialises one byte per valid/ready handshake into a standard asynchronous frame: start bit, data LSB-first, optional parity, then stop bit(s). It sits beside the key/counter/display logic in the Omdazz top level. Its typical client sends the current counter value or ASCII characters to a PC at 115200 baud.

Parameters:
CLK_FREQ, 50000000, FPGA_CLK frequency in Hz
BAUD, 115200, line rate in bit/s
DATA_BITS, 8, payload bits per frame; legal values 5..8
PARITY, 0, 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, number of stop bits; legal values 1 or 2

Ports:
FPGA_CLK   in   1   system clock, rising edge
RESET_BUT  in   1   asynchronous, active-low reset
tx_data    in   8   payload; only bits [DATA_BITS-1:0] are sent
tx_valid   in   1   client has a byte to send
tx_ready   out  1   block can accept a byte this cycle
UART_TXD   out  1   serial line, idles high
tx_busy    out  1   a frame is in progress
tx_done    out  1   one-cycle pulse when the last stop bit ends

Behaviour:
- Bit timing: CLKS_PER_BIT = (CLK_FREQ + BAUD/2) / BAUD. This is 434 at the default parameters. The value must be at least 2; elaboration fails otherwise.
- Reset (RESET_BUT = 0): takes effect immediately, asynchronously.
  - UART_TXD = 1, tx_ready = 1, tx_busy = 0, tx_done = 0.
  - FSM goes to IDLE; bit timer and bit index clear to 0.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- tx_ready = 1 only in IDLE. It is decoded from the state register, with no combinational path from tx_valid.
- Accept: on a rising edge with tx_valid & tx_ready:
  - tx_data is latched into the shift register.
  - If PARITY != 0, the parity bit is computed from the latched bits at this point.
  - FSM moves to START.
  - tx_data changes after the accept edge have no effect on the frame in flight.
- UART_TXD is registered. It drives 0 (start bit) starting on the clock edge that accepts the byte.
- Each bit holds for exactly CLKS_PER_BIT cycles. The bit timer counts 0..CLKS_PER_BIT-1 and wraps at each bit boundary.
- Transitions:
  - START -> DATA.
  - DATA sends bit 0 first, through bit DATA_BITS-1.
  - DATA -> PARITY if PARITY != 0, otherwise DATA -> STOP.
  - PARITY bit value: even = XOR of the data bits; odd = its inverse.
  - STOP drives 1 for STOP_BITS x CLKS_PER_BIT cycles, then goes to IDLE.
- tx_done is high for exactly one cycle: the cycle in which the FSM re-enters IDLE. tx_ready rises in the same cycle.
- tx_busy = 1 in every state except IDLE.
- Frame length from accept to tx_done = CLKS_PER_BIT x (1 + DATA_BITS + (PARITY != 0) + STOP_BITS) cycles.
- Back-to-back: if tx_valid is held high, the next byte is accepted in the first IDLE cycle. The line therefore carries one extra FPGA_CLK cycle of idle (high) between frames, and no other gap.
- tx_valid while busy: ignored. Nothing is queued or latched, and the frame in progress is not disturbed.
- Reset mid-frame: the frame is aborted and UART_TXD returns to 1 immediately. After reset is released, no partial frame resumes.
- No glitches: UART_TXD changes only on FPGA_CLK edges or on reset assertion.

Decomposition:
- Shared package uart_pkg holds:
  - the state encoding (localparams ST_IDLE..ST_STOP);
  - the parity codes PAR_NONE, PAR_EVEN, PAR_ODD;
  - a function clks_per_bit(clk_freq, baud) with the rounding rule above, so a later receiver uses identical timing.
- One sub-module, uart_bit_timer:
  - counts 0..CLKS_PER_BIT-1 while enabled and emits a one-cycle bit_end pulse at the top count;
  - clears when disabled and on reset;
  - is reusable by the future receiver.

Test Plan:
1. Defaults, send 0x55 -> UART_TXD carries 0 then 1,0,1,0,1,0,1,0 then 1. Each level lasts 434 cycles. tx_done pulses exactly 4340 cycles after accept.
2. CLK_FREQ=1000, BAUD=100, PARITY=1, send 0x07 -> 10 cycles per bit. The parity bit is 1 and the frame is 110 cycles. With PARITY=2 the parity bit is 0.
3. Hold tx_valid high with 0x41 then 0x42 -> two correct frames. Exactly 1 idle cycle separates the first stop bit's end from the second start bit.
4. Pulse tx_valid with 0xFF at bit 3 of a 0x00 frame -> the 0x00 frame completes unchanged, 0xFF is never sent, and tx_ready stays 0 until tx_done.
5. Assert RESET_BUT low during data bit 5 -> UART_TXD = 1 and tx_busy = 0 in the same cycle, with no tx_done. After release, tx_ready = 1 and the next accepted byte is sent cleanly.
6. DATA_BITS=7, STOP_BITS=2, send 0xC1 -> bits sent are 1,0,0,0,0,0,1 (bit 7 dropped), followed by a stop high lasting 2 x CLKS_PER_BIT cycles.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity codes and bit-timing rule,
// so transmitter and a future receiver agree on timing.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    // Rounded to the nearest clock count so the baud error stays below half a cycle per bit.
    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return (clk_freq + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled, pulses bit_end at the top count.
// Held at zero while disabled so every enable starts a full bit period.
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic FPGA_CLK,
    input  logic RESET_BUT,
    input  logic en,
    output logic bit_end
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] TOP = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    assign bit_end = en && (cnt == TOP);

    always_ff @(posedge FPGA_CLK or negedge RESET_BUT) begin
        if (!RESET_BUT) begin
            cnt <= '0;
        end else if (!en || bit_end) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: one byte per valid/ready handshake, framed as start, data LSB-first,
// optional parity and stop bit(s) on a registered, glitch-free UART_TXD.
//
//   state     | meaning
//   ----------+--------------------------------------------------
//   ST_IDLE   | line high, tx_ready=1, waiting for tx_valid
//   ST_START  | start bit (0)
//   ST_DATA   | data bits, bit_idx = bit currently on the line
//   ST_PARITY | parity bit latched at accept
//   ST_STOP   | stop bit(s) (1), bit_idx counts stop bits
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 50000000,
    parameter int BAUD      = 115200,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic       FPGA_CLK,
    input  logic       RESET_BUT,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       UART_TXD,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int CPB = clks_per_bit(CLK_FREQ, BAUD);
    localparam logic [7:0] DATA_MASK = 8'hFF >> (8 - DATA_BITS);
    localparam logic [2:0] DATA_LAST = 3'(DATA_BITS - 1);
    localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);

    if (CPB < 2) begin : g_bad_cpb
        $error("uart_tx_frame: CLKS_PER_BIT must be at least 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
        $error("uart_tx_frame: DATA_BITS must be 5..8");
    end
    if (PARITY < PAR_NONE || PARITY > PAR_ODD) begin : g_bad_parity
        $error("uart_tx_frame: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_tx_frame: STOP_BITS must be 1 or 2");
    end

    uart_state_t state;
    logic [7:0]  shreg;
    logic [2:0]  bit_idx;
    logic        par_bit;
    logic        bit_end;

    assign tx_ready = (state == ST_IDLE);
    assign tx_busy  = (state != ST_IDLE);

    uart_bit_timer #(
        .CLKS_PER_BIT(CPB)
    ) u_bit_timer (
        .FPGA_CLK (FPGA_CLK),
        .RESET_BUT(RESET_BUT),
        .en       (tx_busy),
        .bit_end  (bit_end)
    );

    always_ff @(posedge FPGA_CLK or negedge RESET_BUT) begin
        if (!RESET_BUT) begin
            state    <= ST_IDLE;
            UART_TXD <= 1'b1;
            shreg    <= '0;
            bit_idx  <= '0;
            par_bit  <= 1'b0;
            tx_done  <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (tx_valid) begin
                        shreg    <= tx_data;
                        par_bit  <= (^(tx_data & DATA_MASK)) ^ (PARITY == PAR_ODD);
                        bit_idx  <= '0;
                        UART_TXD <= 1'b0;
                        state    <= ST_START;
                    end
                end
                ST_START: begin
                    if (bit_end) begin
                        UART_TXD <= shreg[0];
                        shreg    <= {1'b0, shreg[7:1]};
                        state    <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        if (bit_idx == DATA_LAST) begin
                            bit_idx <= '0;
                            if (PARITY != PAR_NONE) begin
                                UART_TXD <= par_bit;
                                state    <= ST_PARITY;
                            end else begin
                                UART_TXD <= 1'b1;
                                state    <= ST_STOP;
                            end
                        end else begin
                            UART_TXD <= shreg[0];
                            shreg    <= {1'b0, shreg[7:1]};
                            bit_idx  <= bit_idx + 3'd1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (bit_end) begin
                        UART_TXD <= 1'b1;
                        bit_idx  <= '0;
                        state    <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (bit_end) begin
                        if (bit_idx == STOP_LAST) begin
                            bit_idx <= '0;
                            tx_done <= 1'b1;
                            state   <= ST_IDLE;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end
                end
                default: begin
                    UART_TXD <= 1'b1;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: four parameterisations share clock and reset,
// each frame is compared cycle by cycle against a hand-computed bit pattern.
module tb_uart_tx_frame;

    logic       FPGA_CLK = 1'b0;
    logic       RESET_BUT = 1'b0;
    logic [7:0] data [4];
    logic [3:0] valid;
    logic [3:0] ready, txd, busy, done;

    logic [1:0] sel;
    logic       m_txd, m_ready, m_busy, m_done;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 FPGA_CLK = ~FPGA_CLK;

    // u0: defaults (434 clk/bit, 8N1)
    uart_tx_frame u0 (
        .FPGA_CLK(FPGA_CLK), .RESET_BUT(RESET_BUT), .tx_data(data[0]), .tx_valid(valid[0]),
        .tx_ready(ready[0]), .UART_TXD(txd[0]), .tx_busy(busy[0]), .tx_done(done[0])
    );
    // u1: 10 clk/bit, 8E1
    uart_tx_frame #(.CLK_FREQ(1000), .BAUD(100), .PARITY(1)) u1 (
        .FPGA_CLK(FPGA_CLK), .RESET_BUT(RESET_BUT), .tx_data(data[1]), .tx_valid(valid[1]),
        .tx_ready(ready[1]), .UART_TXD(txd[1]), .tx_busy(busy[1]), .tx_done(done[1])
    );
    // u2: 10 clk/bit, 8O1
    uart_tx_frame #(.CLK_FREQ(1000), .BAUD(100), .PARITY(2)) u2 (
        .FPGA_CLK(FPGA_CLK), .RESET_BUT(RESET_BUT), .tx_data(data[2]), .tx_valid(valid[2]),
        .tx_ready(ready[2]), .UART_TXD(txd[2]), .tx_busy(busy[2]), .tx_done(done[2])
    );
    // u3: 10 clk/bit, 7N2
    uart_tx_frame #(.CLK_FREQ(1000), .BAUD(100), .DATA_BITS(7), .STOP_BITS(2)) u3 (
        .FPGA_CLK(FPGA_CLK), .RESET_BUT(RESET_BUT), .tx_data(data[3]), .tx_valid(valid[3]),
        .tx_ready(ready[3]), .UART_TXD(txd[3]), .tx_busy(busy[3]), .tx_done(done[3])
    );

    always_comb begin
        m_txd   = txd[sel];
        m_ready = ready[sel];
        m_busy  = busy[sel];
        m_done  = done[sel];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else
            n_pass++;
    endtask

    // Caller has already raised valid[s] with the byte at a negedge; the next posedge accepts.
    // exp holds the expected line level per bit slot, LSB = start bit.
    task automatic run_frame(input logic [1:0] s, input int n, input int nbits,
                             input logic [15:0] exp, input logic [7:0] next_data,
                             input bit keep_valid, input int inject_k, input string tag);
        int errs [16];
        int done_early = 0;
        int ready_hi = 0;
        int busy_lo = 0;
        for (int b = 0; b < 16; b++) errs[b] = 0;
        sel = s;
        @(posedge FPGA_CLK);
        #1;
        valid[s] = keep_valid;
        data[s]  = next_data;
        for (int k = 0; k < n * nbits; k++) begin
            @(negedge FPGA_CLK);
            if (m_txd !== exp[k / n]) errs[k / n]++;
            if (m_done !== 1'b0) done_early++;
            if (m_ready !== 1'b0) ready_hi++;
            if (m_busy !== 1'b1) busy_lo++;
            if (inject_k >= 0 && k == inject_k) begin
                valid[s] = 1'b1;
                data[s]  = 8'hFF;
            end else if (inject_k >= 0 && k == inject_k + 1) begin
                valid[s] = 1'b0;
            end
        end
        for (int b = 0; b < nbits; b++)
            check($sformatf("%s bit%0d bad cycles", tag, b), errs[b], 0);
        check({tag, " early done"}, done_early, 0);
        check({tag, " ready in frame"}, ready_hi, 0);
        check({tag, " busy dropped"}, busy_lo, 0);
        @(negedge FPGA_CLK);
        check({tag, " done pulse"}, m_done, 1);
        check({tag, " ready at end"}, m_ready, 1);
        check({tag, " busy at end"}, m_busy, 0);
        check({tag, " idle line"}, m_txd, 1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        valid = '0;
        sel   = 2'd0;
        for (int i = 0; i < 4; i++) data[i] = 8'h00;

        #12;
        check("reset txd", txd, 4'hF);
        check("reset ready", ready, 4'hF);
        check("reset busy", busy, 4'h0);
        check("reset done", done, 4'h0);
        @(negedge FPGA_CLK);
        RESET_BUT = 1'b1;
        @(negedge FPGA_CLK);

        // 0x55, 8N1 @ 434: 0,1,0,1,0,1,0,1,0,1
        data[0] = 8'h55; valid[0] = 1'b1;
        run_frame(2'd0, 434, 10, 16'h02AA, 8'h55, 1'b0, -1, "t1_55");

        // 0x07 even parity -> parity 1
        @(negedge FPGA_CLK);
        data[1] = 8'h07; valid[1] = 1'b1;
        run_frame(2'd1, 10, 11, 16'h060E, 8'h00, 1'b0, -1, "t2_even");
        // 0x07 odd parity -> parity 0
        @(negedge FPGA_CLK);
        data[2] = 8'h07; valid[2] = 1'b1;
        run_frame(2'd2, 10, 11, 16'h040E, 8'h00, 1'b0, -1, "t2_odd");

        // 0xC1, 7N2: data 1,0,0,0,0,0,1 then two stop bits
        @(negedge FPGA_CLK);
        data[3] = 8'hC1; valid[3] = 1'b1;
        run_frame(2'd3, 10, 10, 16'h0382, 8'h00, 1'b0, -1, "t6_7n2");

        // back-to-back 0x41, 0x42 with valid held; second start must follow one idle cycle
        @(negedge FPGA_CLK);
        data[0] = 8'h41; valid[0] = 1'b1;
        run_frame(2'd0, 434, 10, 16'h0282, 8'h42, 1'b1, -1, "t3_41");
        run_frame(2'd0, 434, 10, 16'h0284, 8'h00, 1'b0, -1, "t3_42");

        // 0x00 with a 0xFF request pulsed during data bit 3
        @(negedge FPGA_CLK);
        data[0] = 8'h00; valid[0] = 1'b1;
        run_frame(2'd0, 434, 10, 16'h0200, 8'h00, 1'b0, 4 * 434 + 10, "t4_00");
        bad = 0;
        repeat (50) begin
            @(negedge FPGA_CLK);
            if (busy[0] !== 1'b0 || txd[0] !== 1'b1) bad++;
        end
        check("t4 ignored byte not sent", bad, 0);

        // reset during data bit 5 of a 0x00 frame
        @(negedge FPGA_CLK);
        data[0] = 8'h00; valid[0] = 1'b1;
        @(posedge FPGA_CLK);
        #1;
        valid[0] = 1'b0;
        repeat (6 * 434 + 200) @(negedge FPGA_CLK);
        check("t5 mid-frame txd", txd[0], 0);
        check("t5 mid-frame busy", busy[0], 1);
        #2;
        RESET_BUT = 1'b0;
        #1;
        check("t5 reset txd", txd[0], 1);
        check("t5 reset busy", busy[0], 0);
        check("t5 reset done", done[0], 0);
        check("t5 reset ready", ready[0], 1);
        @(negedge FPGA_CLK);
        #1;
        RESET_BUT = 1'b1;
        bad = 0;
        repeat (500) begin
            @(negedge FPGA_CLK);
            if (busy[0] !== 1'b0 || txd[0] !== 1'b1 || done[0] !== 1'b0 || ready[0] !== 1'b1) bad++;
        end
        check("t5 no resume", bad, 0);
        // 0x3C after reset: 0,0,0,1,1,1,1,0,0,1
        data[0] = 8'h3C; valid[0] = 1'b1;
        run_frame(2'd0, 434, 10, 16'h0278, 8'h00, 1'b0, -1, "t5_post");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
